fft_bfly_sched: RTL and testbench

Issue scheduler for the shared radix-2 butterfly (sum/difference unit) in an in-place N-point DIT FFT. On `start` it walks all log2(N) stages and issues one butterfly per cycle: a read address pair for the sample RAM and a twiddle index. After a fixed datapath latency it issues the matching write-back address pair. Between stages it inserts drain bubbles so no stage reads a location before the previous stage has written it.

---
 rtl/fft_bfly_sched.sv | 190 +++++++++++++++++++
 tb/tb_fft_bfly_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched: issue scheduler for a shared radix-2 DIT FFT butterfly.
// Walks every stage, issues one read pair plus twiddle index per cycle, and
// replays each pair as a write-back after BF_LAT cycles. Drain bubbles
// between stages keep a stage from reading data before it has been written.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, hold       begin a transform (IDLE only), pause issue (RUN only)
//   busy, done        not-IDLE flag, one-cycle completion pulse
//   stage             stage currently issuing
//   rd_en, rd_addr_a, rd_addr_b, tw_idx   issue strobe, read pair, twiddle
//   wr_en, wr_addr_a, wr_addr_b           issue strobe and pair, BF_LAT later
module fft_bfly_sched #(
   parameter int LOG2N  = 3,
   parameter int BF_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int AW  = LOG2N;
   localparam int TW  = LOG2N - 1;
   localparam int DLW = 2 * AW + 1;

   localparam logic [AW-1:0] NH     = AW'(1 << (LOG2N - 1));
   localparam logic [AW-1:0] LAST_S = AW'(LOG2N - 1);
   localparam logic [3:0]    LAST_D = 4'(BF_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [AW-1:0]  stage_q, stage_d;
   logic [AW-1:0]  k_q, k_d;
   logic [3:0]     dcnt_q, dcnt_d;
   logic           rd_en_q, rd_en_d;
   logic [AW-1:0]  rd_addr_a_q, rd_addr_a_d;
   logic [AW-1:0]  rd_addr_b_q, rd_addr_b_d;
   logic [TW-1:0]  tw_idx_q, tw_idx_d;
   logic [DLW-1:0] dl_q [BF_LAT];
   logic [DLW-1:0] dl_d [BF_LAT];

   // Issue request and the stage/butterfly it refers to
   logic          issue;
   logic [AW-1:0] iss_s, iss_k;
   logic [AW-1:0] h, g, j, a;

   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      stage_d     = stage_q;
      k_d         = k_q;
      dcnt_d      = dcnt_q;
      rd_en_d     = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      tw_idx_d    = tw_idx_q;
      issue       = 1'b0;
      iss_s       = stage_q;
      iss_k       = k_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               stage_d = '0;
               iss_s   = '0;
               iss_k   = '0;
               issue   = 1'b1;
               k_d     = AW'(1);
            end
         end
         S_RUN: begin
            // k reaches N/2 only once the stage's last pair is on the port
            if (k_q == NH) begin
               state_d = S_DRAIN;
               dcnt_d  = '0;
            end else if (!hold) begin
               issue = 1'b1;
               k_d   = k_q + AW'(1);
            end
         end
         S_DRAIN: begin
            if (dcnt_q == LAST_D) begin
               if (stage_q == LAST_S) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  // first issue of the next stage lands right after the
                  // previous stage's last write
                  state_d = S_RUN;
                  stage_d = stage_q + AW'(1);
                  iss_s   = stage_q + AW'(1);
                  iss_k   = '0;
                  issue   = 1'b1;
                  k_d     = AW'(1);
               end
            end else begin
               dcnt_d = dcnt_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // a = (k >> s) * 2h + (k & (h-1)), b = a + h
      h = AW'(1) << iss_s;
      j = iss_k & (h - AW'(1));
      g = iss_k >> iss_s;
      a = (g << (iss_s + AW'(1))) | j;

      if (issue) begin
         rd_en_d     = 1'b1;
         rd_addr_a_d = a;
         rd_addr_b_d = a | h;
         tw_idx_d    = TW'(j << (LAST_S - iss_s));
      end

      busy_d = (state_d != S_IDLE);
   end

   // Write-back delay line shifts every cycle, carrying bubbles too
   always_comb begin
      dl_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
      for (int i = 1; i < BF_LAT; i++) begin
         dl_d[i] = dl_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stage_q     <= '0;
         k_q         <= '0;
         dcnt_q      <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         tw_idx_q    <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            dl_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         stage_q     <= stage_d;
         k_q         <= k_d;
         dcnt_q      <= dcnt_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         tw_idx_q    <= tw_idx_d;
         for (int i = 0; i < BF_LAT; i++) begin
            dl_q[i] <= dl_d[i];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign stage     = stage_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;
   assign tw_idx    = tw_idx_q;
   assign {wr_en, wr_addr_a, wr_addr_b} = dl_q[BF_LAT-1];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// tb_fft_bfly_sched: directed bench for fft_bfly_sched (LOG2N=3, BF_LAT=2).
// Expected tables list busy,done,stage,rd_en,a,b,tw,wr_en,wa,wb per cycle.
module tb_fft_bfly_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic       busy, done;
   logic [2:0] stage;
   logic       rd_en;
   logic [2:0] rd_addr_a, rd_addr_b;
   logic [1:0] tw_idx;
   logic       wr_en;
   logic [2:0] wr_addr_a, wr_addr_b;

   int vecs  = 0;
   int fails = 0;

   fft_bfly_sched #(.LOG2N(3), .BF_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .stage     (stage),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_idx    (tw_idx),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

   always #5 clk = ~clk;

   // Cycles 1..22 after start in cycle 0, from a freshly reset block
   int full_t [22][10] = '{
      '{1,0,0, 1,0,1,0, 0,0,0},
      '{1,0,0, 1,2,3,0, 0,0,0},
      '{1,0,0, 1,4,5,0, 1,0,1},
      '{1,0,0, 1,6,7,0, 1,2,3},
      '{1,0,0, 0,6,7,0, 1,4,5},
      '{1,0,0, 0,6,7,0, 1,6,7},
      '{1,0,1, 1,0,2,0, 0,6,7},
      '{1,0,1, 1,1,3,2, 0,6,7},
      '{1,0,1, 1,4,6,0, 1,0,2},
      '{1,0,1, 1,5,7,2, 1,1,3},
      '{1,0,1, 0,5,7,2, 1,4,6},
      '{1,0,1, 0,5,7,2, 1,5,7},
      '{1,0,2, 1,0,4,0, 0,5,7},
      '{1,0,2, 1,1,5,1, 0,5,7},
      '{1,0,2, 1,2,6,2, 1,0,4},
      '{1,0,2, 1,3,7,3, 1,1,5},
      '{1,0,2, 0,3,7,3, 1,2,6},
      '{1,0,2, 0,3,7,3, 1,3,7},
      '{1,1,2, 0,3,7,3, 0,3,7},
      '{0,0,2, 0,3,7,3, 0,3,7},
      '{0,0,2, 0,3,7,3, 0,3,7},
      '{0,0,2, 0,3,7,3, 0,3,7}
   };

   // hold high in cycles 2 and 3; previous run left pair (3,7) tw 3
   int hold_t [22][10] = '{
      '{1,0,0, 1,0,1,0, 0,3,7},
      '{1,0,0, 1,2,3,0, 0,3,7},
      '{1,0,0, 0,2,3,0, 1,0,1},
      '{1,0,0, 0,2,3,0, 1,2,3},
      '{1,0,0, 1,4,5,0, 0,2,3},
      '{1,0,0, 1,6,7,0, 0,2,3},
      '{1,0,0, 0,6,7,0, 1,4,5},
      '{1,0,0, 0,6,7,0, 1,6,7},
      '{1,0,1, 1,0,2,0, 0,6,7},
      '{1,0,1, 1,1,3,2, 0,6,7},
      '{1,0,1, 1,4,6,0, 1,0,2},
      '{1,0,1, 1,5,7,2, 1,1,3},
      '{1,0,1, 0,5,7,2, 1,4,6},
      '{1,0,1, 0,5,7,2, 1,5,7},
      '{1,0,2, 1,0,4,0, 0,5,7},
      '{1,0,2, 1,1,5,1, 0,5,7},
      '{1,0,2, 1,2,6,2, 1,0,4},
      '{1,0,2, 1,3,7,3, 1,1,5},
      '{1,0,2, 0,3,7,3, 1,2,6},
      '{1,0,2, 0,3,7,3, 1,3,7},
      '{1,1,2, 0,3,7,3, 0,3,7},
      '{0,0,2, 0,3,7,3, 0,3,7}
   };

   task automatic chk(input string tag, input int cyc,
                      input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_row(input string tag, input int cyc,
                          input int e[10]);
      chk({tag, ".busy"},  cyc, 32'(busy),      e[0]);
      chk({tag, ".done"},  cyc, 32'(done),      e[1]);
      chk({tag, ".stage"}, cyc, 32'(stage),     e[2]);
      chk({tag, ".rd_en"}, cyc, 32'(rd_en),     e[3]);
      chk({tag, ".rd_a"},  cyc, 32'(rd_addr_a), e[4]);
      chk({tag, ".rd_b"},  cyc, 32'(rd_addr_b), e[5]);
      chk({tag, ".tw"},    cyc, 32'(tw_idx),    e[6]);
      chk({tag, ".wr_en"}, cyc, 32'(wr_en),     e[7]);
      chk({tag, ".wr_a"},  cyc, 32'(wr_addr_a), e[8]);
      chk({tag, ".wr_b"},  cyc, 32'(wr_addr_b), e[9]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start in cycle 0, optional hold (cycles 2,3) and stray starts (5,10)
   task automatic do_run(input string tag, input int t[22][10],
                         input bit hold_en, input bit extra_start);
      int ndone;
      ndone = 0;
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         chk_row(tag, c, t[c-1]);
         if (done === 1'b1) ndone++;
         start = extra_start && (c == 5 || c == 10);
         hold  = hold_en && (c == 2 || c == 3);
      end
      start = 1'b0;
      hold  = 1'b0;
      chk({tag, ".done_count"}, 22, 32'(ndone), 32'd1);
   endtask

   initial begin
      // reset, then idle with no start
      repeat (2) tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle", c,
             32'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b,
                  tw_idx, wr_en, wr_addr_a, wr_addr_b}), 32'd0);
      end

      do_run("full", full_t, 1'b0, 1'b0);
      do_run("hold", hold_t, 1'b1, 1'b0);

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      do_run("restart", full_t, 1'b0, 1'b1);

      // reset during stage 1, then restart from clean state
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         start = 1'b0;
      end
      chk("pre_rst.stage", 8, 32'(stage), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst.wr_en", 9, 32'(wr_en), 32'd0);
      chk("rst.busy",  9, 32'(busy),  32'd0);
      chk("rst.rd_en", 9, 32'(rd_en), 32'd0);
      tick();
      chk("rst.busy", 10, 32'(busy), 32'd0);
      tick();
      chk("rst.busy", 11, 32'(busy), 32'd0);
      tick();
      start = 1'b1;
      for (int c = 13; c <= 16; c++) begin
         tick();
         start = 1'b0;
         chk_row("after_rst", c, full_t[c-13]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
